// File: rtl/instruction_package.sv
// Shared types for the regex CPU cluster: instruction-memory arbiter state
// encoding and the width of its memory-latency down-counter.
package instruction_package;

    // Arbiter walks IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESPOND.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    // Wide enough to count MEM_LATENCY-1 for latencies up to 7.
    localparam int ARB_CNT_W = 3;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin selector: scans the request vector starting one past the
// previous grant and wrapping, returning the first requester it finds.
module rr_priority_encoder #(
    parameter int N_CPU = 4
) (
    input  logic [N_CPU-1:0]         req,
    input  logic [$clog2(N_CPU)-1:0] last_grant,
    output logic [$clog2(N_CPU)-1:0] grant,
    output logic                     found
);

    localparam int GW = $clog2(N_CPU);

    logic [GW:0]   sum;
    logic [GW-1:0] idx;

    // Walk last_grant+1 .. last_grant+N_CPU (mod N_CPU); the first hit wins.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so
        // no path through the block leaves a value held, which would infer a latch.
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= N_CPU; i++) begin
            sum = {1'b0, last_grant} + (GW+1)'(i);
            if (sum >= (GW+1)'(N_CPU)) begin
                sum = sum - (GW+1)'(N_CPU);
            end
            idx = sum[GW-1:0];
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regex_cpu_memory_arbiter.sv
// Shares one instruction memory between N_CPU regex CPUs. One fetch is in
// flight at a time; each takes a fixed MEM_LATENCY+2 cycles from request
// sample to the one-hot ready strobe, and the response word is broadcast.
module regex_cpu_memory_arbiter
    import instruction_package::*;
#(
    parameter int N_CPU             = 4,
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEM_LATENCY       = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_CPU-1:0]                     cpu_memory_valid,
    input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   cpu_memory_addr,
    output logic [N_CPU-1:0]                     cpu_memory_ready,
    output logic [MEMORY_WIDTH-1:0]              cpu_memory_data,
    output logic                                 bram_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]         bram_addr,
    input  logic [MEMORY_WIDTH-1:0]              bram_data,
    output logic                                 busy,
    output logic [$clog2(N_CPU)-1:0]             grant_id
);

    localparam int GW = $clog2(N_CPU);
    localparam int AW = MEMORY_ADDR_WIDTH;

    arb_state_t              state_q,      state_d;
    logic [GW-1:0]           grant_q,      grant_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [AW-1:0]           addr_q,       addr_d;
    logic [ARB_CNT_W-1:0]    count_q,      count_d;
    logic [MEMORY_WIDTH-1:0] data_q,       data_d;
    logic                    mask_q,       mask_d;

    logic [N_CPU-1:0] eligible;
    logic [GW-1:0]    rr_grant;
    logic             rr_found;

    // The CPU just served still shows valid in the IDLE cycle after RESPOND;
    // hide it for that one cycle so a stale valid cannot win a second grant.
    assign eligible = cpu_memory_valid & ~(mask_q ? (N_CPU'(1) << last_grant_q) : '0);

    rr_priority_encoder #(
        .N_CPU (N_CPU)
    ) u_rr (
        .req        (eligible),
        .last_grant (last_grant_q),
        .grant      (rr_grant),
        .found      (rr_found)
    );

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_CPU - 1);
            addr_q       <= '0;
            count_q      <= '0;
            data_q       <= '0;
            mask_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of
            // every other flop, independent of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
        end
    end

    // Next-state and datapath update; inputs are looked at only in IDLE.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        count_d      = count_q;
        data_d       = data_q;
        mask_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d      = rr_grant;
                    last_grant_d = rr_grant;
                    addr_d       = cpu_memory_addr[int'(rr_grant)*AW +: AW];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                count_d = ARB_CNT_W'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (count_q == '0) begin
                    data_d  = bram_data;
                    state_d = RESPOND;
                end else begin
                    count_d = count_q - ARB_CNT_W'(1);
                end
            end
            RESPOND: begin
                mask_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so they are glitch-free
    // and forced to zero the instant reset lands.
    always_comb begin
        cpu_memory_ready = '0;
        if (state_q == RESPOND) begin
            cpu_memory_ready = N_CPU'(1) << grant_q;
        end
        cpu_memory_data = data_q;
        bram_en         = (state_q == ISSUE);
        bram_addr       = addr_q;
        busy            = (state_q != IDLE);
        grant_id        = grant_q;
    end

endmodule

// File: doc/regex_cpu_memory_arbiter.md
REGEX_CPU_MEMORY_ARBITER -- requirements
Module: regex_cpu_memory_arbiter

Interface
REQ-001 Parameter N_CPU, default 4: number of regex_cpu_pipelined instances sharing one instruction memory.
REQ-002 Parameter MEMORY_WIDTH, default 20: instruction word width.
REQ-003 Parameter MEMORY_ADDR_WIDTH, default 11: instruction address width.
REQ-004 Parameter MEM_LATENCY, default 1, legal range 1..7: cycles from bram_en to valid bram_data.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 cpu_memory_valid  in  N_CPU  per-CPU fetch request.
REQ-008 cpu_memory_addr  in  N_CPU*MEMORY_ADDR_WIDTH  per-CPU fetch address, slice i belongs to CPU i.
REQ-009 cpu_memory_ready  out  N_CPU  one-hot response strobe.
REQ-010 cpu_memory_data  out  MEMORY_WIDTH  response word, broadcast to all CPUs.
REQ-011 bram_en  out  1  memory read enable.
REQ-012 bram_addr  out  MEMORY_ADDR_WIDTH  memory read address.
REQ-013 bram_data  in  MEMORY_WIDTH  memory read data.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 grant_id  out  $clog2(N_CPU)  index of the CPU currently being served.

Function
REQ-016 The arbiter SHALL have four states: IDLE, ISSUE, WAIT, RESPOND.
REQ-017 In IDLE with any eligible request, the arbiter SHALL select one by round-robin, latch grant_id and that CPU's address, and move to ISSUE.
REQ-018 Round-robin priority SHALL start at index last_grant+1, wrapping from N_CPU-1 to 0; after reset, index 0 has highest priority.
REQ-019 In ISSUE, bram_en SHALL be 1 for exactly one cycle with bram_addr equal to the latched address; next state is WAIT.
REQ-020 WAIT SHALL last exactly MEM_LATENCY cycles, tracked by a down-counter.
REQ-021 bram_data SHALL be captured into the cpu_memory_data register at the end of the last WAIT cycle; next state is RESPOND.
REQ-022 In RESPOND, cpu_memory_ready[grant_id] SHALL be 1 for exactly one cycle, with cpu_memory_data valid in that same cycle; next state is IDLE.
REQ-023 cpu_memory_data SHALL hold its value until the next capture.
REQ-024 The request-to-response latency SHALL be fixed: a request sampled in IDLE at cycle 0 gives ready at cycle MEM_LATENCY+2.
REQ-025 Eligibility rule: the CPU just served SHALL be masked for the one IDLE cycle that follows RESPOND, because its valid is still high then; no re-grant is allowed off that stale valid.
REQ-026 Simultaneous requests from all CPUs SHALL be served in rotating order, with no CPU served twice before every other pending CPU has been served once.
REQ-027 The arbiter SHALL ignore changes to cpu_memory_valid and cpu_memory_addr outside IDLE, including a withdrawn request.
REQ-028 In every non-RESPOND cycle, cpu_memory_ready SHALL be all zeros.
REQ-029 At most one bram_en pulse SHALL be outstanding at a time.

Reset
REQ-030 When rst is low, the arbiter SHALL asynchronously force: state=IDLE, cpu_memory_ready=0, cpu_memory_data=0, bram_en=0, bram_addr=0, busy=0, grant_id=0, last_grant=N_CPU-1, counter=0.
REQ-031 Reset asserted mid-transaction SHALL drop that transaction with no ready pulse; after release the CPU must re-request.

Structure
REQ-032 The arbiter state enum SHALL be defined in instruction_package, next to the existing instruction typedefs.
REQ-033 The round-robin selector SHALL be a separate sub-module, rr_priority_encoder: inputs are the request vector and last_grant; outputs are the grant index and a found flag.

Verification
REQ-034 Single request: CPU2 requests addr 0x0F5, memory returns 0x1ABCD -> bram_addr 0x0F5 at cycle 1, cpu_memory_ready=4'b0100 at cycle 3, data 0x1ABCD.
REQ-035 All four CPUs request at once after reset -> grant order 0,1,2,3; each ready pulse is one cycle; pulses are spaced 4 cycles apart.
REQ-036 CPU1 holds valid one cycle after its ready while CPU3 requests -> next grant goes to CPU3, and CPU1 is not re-served.
REQ-037 MEM_LATENCY=3, CPU0 requests addr 0x138 -> ready at cycle 5 with the data presented at cycle 4.
REQ-038 rst driven low during WAIT -> all outputs zero immediately, no ready pulse; after release a new CPU0 request completes normally.
REQ-039 Randomised addresses 245..311 per CPU against a memory model -> every ready carries the word stored at that CPU's requested address.
